// File: rtl/lattice_single_port_ram_bwe.sv
// Single-port RAM with valid/ready request port, per-lane write mask, read response strobe and zero-fill.
// Optional macro SP_RAM_OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module lattice_single_port_ram_bwe #(
   parameter int              AW       = 5,
   parameter int              DW       = 8,
   parameter int              LW       = 8,
   parameter logic [DW-1:0]   INIT_VAL = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [AW-1:0]       req_addr,
   input  logic [DW/LW-1:0]    req_wmask,
   input  logic [DW-1:0]       req_wdata,
   input  logic                clear,
   output logic                rsp_valid,
   output logic [DW-1:0]       rsp_data,
   output logic                fill_busy
);
   localparam int SIZE = 2**AW;
   localparam int NL   = DW/LW;
`ifdef SP_RAM_OUT_REG_EN
   localparam int STAGES = 3;
`else
   localparam int STAGES = 2;
`endif

   typedef enum logic {FILL, RUN} state_t;

   state_t                  state, state_n;
   logic [AW-1:0]           fill_addr, fill_addr_n;
   logic [NL-1:0][LW-1:0]   mem [SIZE];
   logic [STAGES:1]         vld_pipe;
   logic [STAGES-1:1][DW-1:0] dpipe;
   logic                    fill_we, wr_acc, rd_acc;

   // Requests are dropped while reset is held so the array stays untouched.
   assign fill_we = (state == FILL) && !reset;
   assign wr_acc  = req_valid && req_ready && req_we && !reset;
   assign rd_acc  = req_valid && req_ready && !req_we && !reset;

   always_comb begin
      state_n     = state;
      fill_addr_n = fill_addr;
      case (state)
         FILL: begin
            fill_addr_n = fill_addr + AW'(1);
            if (fill_addr == {AW{1'b1}}) state_n = RUN;
         end
         RUN: begin
            if (clear) begin
               state_n     = FILL;
               fill_addr_n = '0;
            end
         end
         default: state_n = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FILL;
         fill_addr <= '0;
         req_ready <= 1'b0;
         fill_busy <= 1'b1;
      end else begin
         state     <= state_n;
         fill_addr <= fill_addr_n;
         req_ready <= (state_n == RUN);
         fill_busy <= (state_n == FILL);
      end
   end

   // Single write port: fill and request writes never overlap since req_ready is low in FILL.
   always_ff @(posedge clk) begin
      if (fill_we)
         mem[fill_addr] <= INIT_VAL;
      else if (wr_acc)
         for (int k = 0; k < NL; k++)
            if (req_wmask[k]) mem[req_addr][k] <= req_wdata[k*LW +: LW];
      if (rd_acc) dpipe[1] <= mem[req_addr];
      for (int i = 2; i < STAGES; i++)
         if (vld_pipe[i-1]) dpipe[i] <= dpipe[i-1];
   end

   // Clear does not flush the pipe; only reset drops in-flight reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         rsp_data <= '0;
      end else begin
         vld_pipe[1] <= rd_acc;
         for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
         if (vld_pipe[STAGES-1]) rsp_data <= dpipe[STAGES-1];
      end
   end

   assign rsp_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_lattice_single_port_ram_bwe.sv
// Directed bench for lattice_single_port_ram_bwe (AW=5, DW=32, LW=8, INIT_VAL=0).
module tb_lattice_single_port_ram_bwe;
`ifdef SP_RAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        reset, req_valid, req_we, clear;
   logic        req_ready, rsp_valid, fill_busy;
   logic [4:0]  req_addr;
   logic [3:0]  req_wmask;
   logic [31:0] req_wdata, rsp_data;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n;

   lattice_single_port_ram_bwe #(.AW(5), .DW(32), .LW(8), .INIT_VAL(32'h0)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
      .clear(clear), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .fill_busy(fill_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("%s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
      tick();
      req_valid = 1'b0; req_we = 1'b0;
   endtask

   // Read accepted at edge A; response must appear exactly LAT edges later.
   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wmask = 4'hF;
      tick();
      req_valid = 1'b0;
      chk({tag, "_early"}, {31'b0, rsp_valid}, 32'd0);
      for (int j = 1; j <= LAT; j++) begin
         tick();
         if (j < LAT) chk({tag, "_early"}, {31'b0, rsp_valid}, 32'd0);
      end
      chk({tag, "_vld"}, {31'b0, rsp_valid}, 32'd1);
      chk({tag, "_data"}, rsp_data, exp);
      tick();
      chk({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (!req_ready && cnt < 100) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; clear = 1'b0;
      req_addr = '0; req_wmask = '0; req_wdata = '0;

      // 1: reset state, fill length, initial contents
      repeat (3) tick();
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_busy",  {31'b0, fill_busy}, 32'd1);
      chk("rst_rvld",  {31'b0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_data, 32'd0);
      reset = 1'b0;
      repeat (31) tick();
      chk("fill31_ready", {31'b0, req_ready}, 32'd0);
      chk("fill31_busy",  {31'b0, fill_busy}, 32'd1);
      tick();
      chk("fill32_ready", {31'b0, req_ready}, 32'd1);
      chk("fill32_busy",  {31'b0, fill_busy}, 32'd0);
      rd("init0", 5'd0, 32'h0);
      rd("init17", 5'd17, 32'h0);
      rd("init31", 5'd31, 32'h0);

      // 2: lane masks, zero mask no-op, write-then-read
      wr(5'd5, 32'hA1B2C3D4, 4'hF);
      wr(5'd5, 32'h11223344, 4'b0101);
      rd("mask", 5'd5, 32'hA122C344);
      wr(5'd5, 32'hFFFFFFFF, 4'h0);
      rd("mask0", 5'd5, 32'hA122C344);
      wr(5'd9, 32'hDEADBEEF, 4'hF);
      rd("wr_rd", 5'd9, 32'hDEADBEEF);

      // 3: fill pattern, 32 back-to-back reads
      for (int i = 0; i < 32; i++) wr(5'(i), 32'(i * 3), 4'hF);
      for (int i = 0; i < 32 + LAT; i++) begin
         req_valid = (i < 32); req_we = 1'b0; req_addr = 5'(i);
         tick();
         if (i >= LAT) begin
            chk("b2b_vld", {31'b0, rsp_valid}, 32'd1);
            chk("b2b_data", rsp_data, 32'((i - LAT) * 3));
         end else begin
            chk("b2b_early", {31'b0, rsp_valid}, 32'd0);
         end
      end
      req_valid = 1'b0;
      tick();
      chk("b2b_end_vld", {31'b0, rsp_valid}, 32'd0);
      chk("b2b_hold", rsp_data, 32'h5D);

      // 4: read and clear in the same cycle
      wr(5'd7, 32'h55, 4'hF);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7; clear = 1'b1;
      tick();
      req_valid = 1'b0; clear = 1'b0;
      chk("clr_ready", {31'b0, req_ready}, 32'd0);
      chk("clr_busy",  {31'b0, fill_busy}, 32'd1);
      repeat (LAT) tick();
      chk("clr_rvld", {31'b0, rsp_valid}, 32'd1);
      chk("clr_rdata", rsp_data, 32'h55);
      wait_ready(n);
      chk("clr_fill_len", 32'(n + LAT), 32'd32);
      rd("clr_zero", 5'd7, 32'h0);

      // 5: reset mid-fill, then reset with a read in flight
      reset = 1'b1; tick(); reset = 1'b0;
      repeat (10) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_busy", {31'b0, fill_busy}, 32'd1);
      wait_ready(n);
      chk("mid_fill_len", 32'(n), 32'd32);
      wr(5'd3, 32'h77, 4'hF);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd3;
      tick();
      req_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_flight_vld", {31'b0, rsp_valid}, 32'd0);
      chk("rst_flight_data", rsp_data, 32'h0);
      tick();
      chk("rst_flight_vld2", {31'b0, rsp_valid}, 32'd0);

      // 6: clear during fill is ignored (one fill edge already consumed above)
      n = 1;
      while (!req_ready && n < 100) begin
         clear = (n == 19);
         tick();
         n++;
      end
      clear = 1'b0;
      chk("fillclr_len", 32'(n), 32'd32);
      rd("fillclr_rd", 5'd3, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
